// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single memory port between instruction fetch and load/store.
// One transaction in flight, data side preferred, fetch starvation bounded, response timeout.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX  = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [SW-1:0]   r_streak;
    logic [TW-1:0]   r_tcnt;
    logic            r_store;

    logic            w_idle;
    logic            w_grant_d;
    logic            w_grant_i;
    logic            w_expired;
    logic            w_done;

    // Fetch is forced only when it is waiting and data has used up its streak allowance.
    assign w_idle    = (r_state == IDLE) && !rst;
    assign w_grant_d = w_idle && d_req && !(if_req && (r_streak == STREAK_MAX));
    assign w_grant_i = w_idle && !w_grant_d && if_req;
    assign w_expired = (r_tcnt == TIMEOUT_CNT);
    assign w_done    = (r_state != IDLE) && (mem_rvalid || w_expired);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next_state = BUSY_D;
                end else if (w_grant_i) begin
                    w_next_state = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_done) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        if_err    = 1'b0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        d_err     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        d_gnt     = 1'b1;
                        mem_req   = 1'b1;
                        mem_we    = d_we;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                        mem_be    = d_be;
                    end else if (w_grant_i) begin
                        if_gnt    = 1'b1;
                        mem_req   = 1'b1;
                        mem_addr  = if_addr;
                        mem_be    = 4'hF;
                    end
                end
                BUSY_I: begin
                    if (mem_rvalid) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end else if (w_expired) begin
                        if_rvalid = 1'b1;
                        if_err    = 1'b1;
                    end
                end
                BUSY_D: begin
                    // A real response beats a simultaneous timeout; stores never return data.
                    if (mem_rvalid) begin
                        d_rvalid = 1'b1;
                        d_rdata  = r_store ? '0 : mem_rdata;
                    end else if (w_expired) begin
                        d_rvalid = 1'b1;
                        d_err    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (w_grant_d) begin
            if (if_req && (r_streak != STREAK_MAX)) begin
                r_streak <= r_streak + SW'(1);
            end else if (!if_req) begin
                r_streak <= '0;
            end
        end else if (w_grant_i) begin
            r_streak <= '0;
        end
    end

    // Timeout counter reads 1 in the first busy cycle, so expiry lands TIMEOUT cycles after grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_grant_d || w_grant_i) begin
            r_tcnt <= TW'(1);
        end else if (w_done) begin
            r_tcnt <= '0;
        end else if (r_state != IDLE) begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_store <= 1'b0;
        end else if (w_grant_d) begin
            r_store <= d_we;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized transactions checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dwe, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic [3:0] dbe,
                                 input logic mv, input logic [31:0] md);
        if_req     = ir;
        if_addr    = ia;
        d_req      = dr;
        d_we       = dwe;
        d_addr     = da;
        d_wdata    = dwd;
        d_be       = dbe;
        mem_rvalid = mv;
        mem_rdata  = md;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput(tag, {20'd0, mem_be, if_gnt, d_gnt, mem_req, mem_we,
                          if_rvalid, d_rvalid, if_err, d_err}, 32'd0);
    endtask

    logic        ifPend, dPend, dWe, dWin, expRv, expErr;
    logic [31:0] ifA, dA, dWd, rd, expData;
    logic [3:0]  dBe;
    int          streak, k;

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 1'b0, 32'h0);
        settle();
        checkQuiet("reset_outputs");
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        settle();
        checkQuiet("post_reset_idle");

        // Fetch only, memory answers two cycles after the grant.
        nextCycle();
        applyStimulus(1'b1, 32'h0000_302C, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        settle();
        checkOutput("fetch_gnt", {31'd0, if_gnt}, 32'd1);
        checkOutput("fetch_mem_req", {31'd0, mem_req}, 32'd1);
        checkOutput("fetch_mem_addr", mem_addr, 32'h302C);
        checkOutput("fetch_mem_be", {28'd0, mem_be}, 32'hF);
        checkOutput("fetch_mem_we", {31'd0, mem_we}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        settle();
        checkOutput("fetch_wait_rvalid", {31'd0, if_rvalid}, 32'd0);
        checkOutput("fetch_wait_mem_req", {31'd0, mem_req}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0200_8167);
        settle();
        checkOutput("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
        checkOutput("fetch_rdata", if_rdata, 32'h0200_8167);
        checkOutput("fetch_err", {31'd0, if_err}, 32'd0);

        // Simultaneous fetch and load: data first, fetch right after the load completes.
        nextCycle();
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, 32'h0);
        settle();
        checkOutput("simul_d_gnt", {31'd0, d_gnt}, 32'd1);
        checkOutput("simul_if_gnt", {31'd0, if_gnt}, 32'd0);
        checkOutput("simul_mem_addr", mem_addr, 32'h1000);
        nextCycle();
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hCAFE_0001);
        settle();
        checkOutput("simul_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        checkOutput("simul_d_rdata", d_rdata, 32'hCAFE_0001);
        checkOutput("simul_no_if_gnt_busy", {31'd0, if_gnt}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        settle();
        checkOutput("simul_if_gnt_after", {31'd0, if_gnt}, 32'd1);
        checkOutput("simul_if_addr", mem_addr, 32'h400);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1111_2222);
        settle();
        checkOutput("simul_if_rdata", if_rdata, 32'h1111_2222);

        // Starvation bound: with both held high expect D,D,D,D,IF,D.
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF, 1'b0, 32'h0);
            settle();
            checkOutput("starve_if_gnt", {31'd0, if_gnt}, {31'd0, i == 4});
            checkOutput("starve_d_gnt", {31'd0, d_gnt}, {31'd0, i != 4});
            nextCycle();
            applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF, 1'b1, 32'h55);
            settle();
            checkOutput("starve_rvalid", {30'd0, if_rvalid, d_rvalid},
                        (i == 4) ? 32'd2 : 32'd1);
        end

        // Store passes through and acknowledges with zero data.
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0011, 1'b0, 32'h0);
        settle();
        checkOutput("store_gnt", {31'd0, d_gnt}, 32'd1);
        checkOutput("store_mem_we", {31'd0, mem_we}, 32'd1);
        checkOutput("store_mem_be", {28'd0, mem_be}, 32'h3);
        checkOutput("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        checkOutput("store_mem_addr", mem_addr, 32'h20);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1234_5678);
        settle();
        checkOutput("store_rvalid", {31'd0, d_rvalid}, 32'd1);
        checkOutput("store_rdata", d_rdata, 32'h0);
        checkOutput("store_err", {31'd0, d_err}, 32'd0);

        // Timeout: error completion exactly 16 cycles after the grant, stray response ignored.
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 32'h0);
        settle();
        checkOutput("tmo_gnt", {31'd0, d_gnt}, 32'd1);
        for (int c = 1; c <= 16; c++) begin
            nextCycle();
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
            settle();
            checkOutput("tmo_rvalid", {31'd0, d_rvalid}, {31'd0, c == 16});
            if (c == 16) begin
                checkOutput("tmo_err", {31'd0, d_err}, 32'd1);
                checkOutput("tmo_rdata", d_rdata, 32'h0);
            end
        end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h9999_9999);
        settle();
        checkQuiet("tmo_stray_ignored");

        // Reset while a fetch is outstanding; the late response must vanish.
        nextCycle();
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        settle();
        checkOutput("rstmid_gnt", {31'd0, if_gnt}, 32'd1);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        settle();
        checkQuiet("rstmid_during_reset");
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h7777_0000);
        settle();
        checkQuiet("rstmid_late_rvalid");
        checkOutput("rstmid_rdata", if_rdata, 32'h0);

        // Randomized transactions against a transaction-level model.
        ifPend = 1'b0;
        dPend  = 1'b0;
        streak = 0;
        ifA = '0; dA = '0; dWd = '0; dBe = '0; dWe = 1'b0;
        for (int t = 0; t < 150; t++) begin
            nextCycle();
            if (!ifPend && $urandom_range(0, 1) == 1) begin
                ifPend = 1'b1;
                ifA    = $urandom & 32'hFFFF_FFFC;
            end
            if (!dPend && $urandom_range(0, 1) == 1) begin
                dPend = 1'b1;
                dWe   = 1'($urandom_range(0, 1));
                dA    = $urandom;
                dWd   = $urandom;
                dBe   = 4'($urandom_range(0, 15));
            end
            applyStimulus(ifPend, ifA, dPend, dWe, dA, dWd, dBe,
                          1'($urandom_range(0, 1)), $urandom);
            settle();
            if (!ifPend && !dPend) begin
                checkQuiet("rnd_idle");
                continue;
            end
            dWin = dPend && !(ifPend && streak == 4);
            checkOutput("rnd_if_gnt", {31'd0, if_gnt}, {31'd0, !dWin});
            checkOutput("rnd_d_gnt", {31'd0, d_gnt}, {31'd0, dWin});
            checkOutput("rnd_mem_req", {31'd0, mem_req}, 32'd1);
            checkOutput("rnd_mem_addr", mem_addr, dWin ? dA : ifA);
            checkOutput("rnd_mem_we", {31'd0, mem_we}, {31'd0, dWin && dWe});
            checkOutput("rnd_mem_be", {28'd0, mem_be}, {28'd0, dWin ? dBe : 4'hF});
            checkOutput("rnd_idle_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
            if (dWin) begin
                checkOutput("rnd_mem_wdata", mem_wdata, dWd);
                streak = ifPend ? ((streak < 4) ? streak + 1 : 4) : 0;
                dPend  = 1'b0;
            end else begin
                streak = 0;
                ifPend = 1'b0;
            end
            k = $urandom_range(1, 20);
            for (int c = 1; c <= 16; c++) begin
                nextCycle();
                rd = $urandom;
                applyStimulus(ifPend, ifA, dPend, dWe, dA, dWd, dBe, 1'(c == k), rd);
                settle();
                expRv   = (c == k) || (c == 16);
                expErr  = (c != k) && (c == 16);
                expData = (c == k && !(dWin && dWe)) ? rd : 32'h0;
                checkOutput("rnd_busy_quiet", {29'd0, if_gnt, d_gnt, mem_req}, 32'd0);
                checkOutput("rnd_rvalid", {30'd0, if_rvalid, d_rvalid},
                            {30'd0, expRv && !dWin, expRv && dWin});
                if (expRv) begin
                    checkOutput("rnd_err", {31'd0, dWin ? d_err : if_err}, {31'd0, expErr});
                    checkOutput("rnd_rdata", dWin ? d_rdata : if_rdata, expData);
                    break;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
